// File: rtl/mem_read_a.sv
// mem_read_a
// Read-side sequencer for the N1 A-operand banks. The banks are filled
// row-interleaved: bank r holds rows r, r+N1, ... and a word sits at in-bank
// address phase*M2 + col.
//
// The block walks every row-phase of A and repeats each phase once per
// B column tile. The bank-0 stream is then skewed one cycle per row, so the
// operands arrive at the west edge of the systolic array already aligned.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         pulse that begins a full read pass (only honoured in IDLE)
//   M2            inner dimension (columns of A)
//   M1dN1         number of row-phases of A
//   M3dN2         number of B column tiles (repeats per phase)
//   ready         array accepts a beat; low freezes the whole block
//   rd_addr_A     per-bank read address, bank r at [r*ADDR_W +: ADDR_W]
//   rd_en_A       per-bank read enable
//   last_k_A      per-bank flag marking the k == M2-1 beat (accumulator flush)
//   busy          pass in progress
//   done          one-cycle pulse at end of pass
module mem_read_a #(
    parameter int N1           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MATRIXSIZE_W-1:0]  M2,
    input  logic [MATRIXSIZE_W-1:0]  M1dN1,
    input  logic [MATRIXSIZE_W-1:0]  M3dN2,
    input  logic                     ready,
    output logic [N1*ADDR_W-1:0]     rd_addr_A,
    output logic [N1-1:0]            rd_en_A,
    output logic [N1-1:0]            last_k_A,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

    localparam logic [MATRIXSIZE_W-1:0] ONE       = MATRIXSIZE_W'(1);
    localparam logic [MATRIXSIZE_W-1:0] DRAIN_MAX = MATRIXSIZE_W'(N1 - 2);

    state_t state_q, state_d;

    logic [MATRIXSIZE_W-1:0] m2_q, m1_q, m3_q;
    logic [MATRIXSIZE_W-1:0] k_q, rep_q, phase_q, drain_q;
    logic [ADDR_W-1:0]       offset_q;

    logic k_last, rep_last, phase_last, last_beat, dims_zero;

    logic              b0_en, b0_last;
    logic [ADDR_W-1:0] b0_addr;

    logic [ADDR_W-1:0] stg_addr [N1-1];
    logic              stg_en   [N1-1];
    logic              stg_last [N1-1];

    assign k_last     = (k_q == m2_q - ONE);
    assign rep_last   = (rep_q == m3_q - ONE);
    assign phase_last = (phase_q == m1_q - ONE);
    assign last_beat  = k_last && rep_last && phase_last;
    assign dims_zero  = (M2 == '0) || (M1dN1 == '0) || (M3dN2 == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic plus the bank-0 beat and status outputs. Every
    // transition waits for ready so a stall freezes DRAIN and FIN as well.
    always_comb begin
        state_d = state_q;
        b0_en   = 1'b0;
        b0_last = 1'b0;
        b0_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && ready) state_d = dims_zero ? FIN : STREAM;
            end
            STREAM: begin
                b0_en   = 1'b1;
                b0_last = k_last;
                b0_addr = offset_q + k_q[ADDR_W-1:0];
                busy    = 1'b1;
                if (ready && last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (ready && drain_q == DRAIN_MAX) state_d = FIN;
            end
            FIN: begin
                done = 1'b1;
                if (ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loop counters. k is innermost, then rep, then phase. The phase offset is
    // an accumulator, so no multiplier is needed, and the address wraps at
    // ADDR_W. The offset is cleared after the last beat so that idle addresses
    // read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            m2_q     <= '0;
            m1_q     <= '0;
            m3_q     <= '0;
            k_q      <= '0;
            rep_q    <= '0;
            phase_q  <= '0;
            drain_q  <= '0;
            offset_q <= '0;
        end else if (ready) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m2_q     <= M2;
                        m1_q     <= M1dN1;
                        m3_q     <= M3dN2;
                        k_q      <= '0;
                        rep_q    <= '0;
                        phase_q  <= '0;
                        drain_q  <= '0;
                        offset_q <= '0;
                    end
                end
                STREAM: begin
                    drain_q <= '0;
                    if (!k_last) begin
                        k_q <= k_q + ONE;
                    end else begin
                        k_q <= '0;
                        if (!rep_last) begin
                            rep_q <= rep_q + ONE;
                        end else begin
                            rep_q <= '0;
                            if (phase_last) begin
                                phase_q  <= '0;
                                offset_q <= '0;
                            end else begin
                                phase_q  <= phase_q + ONE;
                                offset_q <= offset_q + m2_q[ADDR_W-1:0];
                            end
                        end
                    end
                end
                DRAIN: drain_q <= drain_q + ONE;
                default: ;
            endcase
        end
    end

    // Skew pipeline. Stage i feeds bank i+1. Outside STREAM the bank-0 beat is
    // all zeros, so DRAIN flushes the stages with empty beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N1-1; i++) begin
                stg_addr[i] <= '0;
                stg_en[i]   <= 1'b0;
                stg_last[i] <= 1'b0;
            end
        end else if (ready) begin
            stg_addr[0] <= b0_addr;
            stg_en[0]   <= b0_en;
            stg_last[0] <= b0_last;
            for (int i = 1; i < N1-1; i++) begin
                stg_addr[i] <= stg_addr[i-1];
                stg_en[i]   <= stg_en[i-1];
                stg_last[i] <= stg_last[i-1];
            end
        end
    end

    // Per-bank outputs. The enable is gated by ready combinationally, so a
    // stalled beat is never issued twice.
    always_comb begin
        rd_addr_A = '0;
        rd_en_A   = '0;
        last_k_A  = '0;
        rd_addr_A[ADDR_W-1:0] = b0_addr;
        rd_en_A[0]            = b0_en & ready;
        last_k_A[0]           = b0_last & b0_en;
        for (int r = 1; r < N1; r++) begin
            rd_addr_A[r*ADDR_W +: ADDR_W] = stg_addr[r-1];
            rd_en_A[r]                    = stg_en[r-1] & ready;
            last_k_A[r]                   = stg_last[r-1] & stg_en[r-1];
        end
    end

endmodule

// File: tb/tb_mem_read_a.sv
// tb_mem_read_a
// Directed bench for mem_read_a with N1=4, ADDR_W=12. Expected bank-0 beat
// lists are written out by hand. Bank r expects the same list r cycles later.
module tb_mem_read_a;

    localparam int N1 = 4;
    localparam int MW = 16;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst, start, ready;
    logic [MW-1:0]     M2, M1dN1, M3dN2;
    logic [N1*AW-1:0]  rd_addr_A;
    logic [N1-1:0]     rd_en_A, last_k_A;
    logic              busy, done;

    int total = 0;
    int bad   = 0;

    int exp_addr[$];
    int exp_last[$];

    always #5 clk = ~clk;

    mem_read_a #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .M2        (M2),
        .M1dN1     (M1dN1),
        .M3dN2     (M3dN2),
        .ready     (ready),
        .rd_addr_A (rd_addr_A),
        .rd_en_A   (rd_en_A),
        .last_k_A  (last_k_A),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        exp_addr = {0, 1, 2, 3, 4, 5};
        exp_last = {0, 0, 1, 0, 0, 1};
    endtask

    task automatic load_repeat();
        exp_addr = {0, 1, 0, 1, 2, 3, 2, 3};
        exp_last = {0, 1, 0, 1, 0, 1, 0, 1};
    endtask

    // Expected per-bank view in the adv-th advancing cycle after start.
    function automatic void expect_at(input int adv,
                                      output logic [N1*AW-1:0] ea,
                                      output logic [N1-1:0] ee,
                                      output logic [N1-1:0] el);
        ea = '0;
        ee = '0;
        el = '0;
        for (int r = 0; r < N1; r++) begin
            int j;
            j = adv - 1 - r;
            if (j >= 0 && j < exp_addr.size()) begin
                ea[r*AW +: AW] = AW'(exp_addr[j]);
                ee[r]          = 1'b1;
                el[r]          = (exp_last[j] != 0);
            end
        end
    endfunction

    // Applies the dimensions and pulses start across one edge. On return the
    // bench is in cycle t+1.
    task automatic begin_pass(input int m2, input int m1, input int m3);
        M2    = MW'(m2);
        M1dN1 = MW'(m1);
        M3dN2 = MW'(m3);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        M2    = '0;
        M1dN1 = '0;
        M3dN2 = '0;
        step();
        step();
        total++;
        if (rd_addr_A !== '0) begin
            bad++;
            $display("[TB] FAIL reset addr got=%h want=0", rd_addr_A);
        end
        total++;
        if ({rd_en_A, last_k_A, busy, done} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL reset flags got=%b want=0", {rd_en_A, last_k_A, busy, done});
        end
        rst = 1'b0;
        step();
        total++;
        if ({rd_en_A, last_k_A, busy, done} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL idle flags got=%b want=0", {rd_en_A, last_k_A, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [N1*AW-1:0] ea;
        logic [N1-1:0]    ee, el;
        load_basic();
        begin_pass(3, 2, 1);
        for (int c = 1; c <= 12; c++) begin
            expect_at(c, ea, ee, el);
            total++;
            if (rd_addr_A !== ea) begin
                bad++;
                $display("[TB] FAIL basic addr c=%0d got=%h want=%h", c, rd_addr_A, ea);
            end
            total++;
            if ({rd_en_A, last_k_A, busy, done} !== {ee, el, (c <= 9), (c == 10)}) begin
                bad++;
                $display("[TB] FAIL basic flags c=%0d got=%b want=%b", c,
                         {rd_en_A, last_k_A, busy, done}, {ee, el, (c <= 9), (c == 10)});
            end
            step();
        end
    endtask

    task automatic test_repeat();
        logic [N1*AW-1:0] ea;
        logic [N1-1:0]    ee, el;
        load_repeat();
        begin_pass(2, 2, 2);
        for (int c = 1; c <= 14; c++) begin
            expect_at(c, ea, ee, el);
            total++;
            if (rd_addr_A !== ea) begin
                bad++;
                $display("[TB] FAIL repeat addr c=%0d got=%h want=%h", c, rd_addr_A, ea);
            end
            total++;
            if ({rd_en_A, last_k_A, busy, done} !== {ee, el, (c <= 11), (c == 12)}) begin
                bad++;
                $display("[TB] FAIL repeat flags c=%0d got=%b want=%b", c,
                         {rd_en_A, last_k_A, busy, done}, {ee, el, (c <= 11), (c == 12)});
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [N1*AW-1:0] ea;
        logic [N1-1:0]    ee, el;
        int               stalls;
        stalls = 0;
        load_basic();
        begin_pass(3, 2, 1);
        for (int c = 1; c <= 15; c++) begin
            int adv;
            ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            adv = c - stalls;
            expect_at(adv, ea, ee, el);
            ee = ee & {N1{ready}};
            total++;
            if (rd_addr_A !== ea) begin
                bad++;
                $display("[TB] FAIL stall addr c=%0d got=%h want=%h", c, rd_addr_A, ea);
            end
            total++;
            if ({rd_en_A, last_k_A, busy, done} !== {ee, el, (adv <= 9), (adv == 10)}) begin
                bad++;
                $display("[TB] FAIL stall flags c=%0d got=%b want=%b", c,
                         {rd_en_A, last_k_A, busy, done}, {ee, el, (adv <= 9), (adv == 10)});
            end
            if (!ready) stalls++;
            step();
        end
        ready = 1'b1;
    endtask

    task automatic test_zero_dim();
        begin_pass(3, 2, 0);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({rd_addr_A, rd_en_A, last_k_A, busy, done} !== {{(N1*AW+9){1'b0}}, (c == 1)}) begin
                bad++;
                $display("[TB] FAIL zero_dim c=%0d got en=%b busy=%b done=%b want done=%b",
                         c, rd_en_A, busy, done, (c == 1));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [N1*AW-1:0] ea;
        logic [N1-1:0]    ee, el;
        load_basic();
        begin_pass(3, 2, 1);
        for (int c = 1; c <= 4; c++) begin
            expect_at(c, ea, ee, el);
            total++;
            if ({rd_addr_A, rd_en_A, last_k_A} !== {ea, ee, el}) begin
                bad++;
                $display("[TB] FAIL rstmid pre c=%0d got=%h/%b want=%h/%b", c,
                         rd_addr_A, rd_en_A, ea, ee);
            end
            if (c == 4) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        for (int c = 5; c <= 14; c++) begin
            total++;
            if ({rd_addr_A, rd_en_A, last_k_A, busy, done} !== '0) begin
                bad++;
                $display("[TB] FAIL rstmid quiet c=%0d got addr=%h en=%b busy=%b done=%b",
                         c, rd_addr_A, rd_en_A, busy, done);
            end
            step();
        end
        begin_pass(3, 2, 1);
        for (int c = 1; c <= 12; c++) begin
            expect_at(c, ea, ee, el);
            total++;
            if ({rd_addr_A, rd_en_A, last_k_A, busy, done} !== {ea, ee, el, (c <= 9), (c == 10)}) begin
                bad++;
                $display("[TB] FAIL rstmid restart c=%0d got=%h/%b/%b%b want=%h/%b/%b%b", c,
                         rd_addr_A, rd_en_A, busy, done, ea, ee, (c <= 9), (c == 10));
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        logic [N1*AW-1:0] ea;
        logic [N1-1:0]    ee, el;
        load_basic();
        begin_pass(3, 2, 1);
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) begin
                start = 1'b1;
                M2    = MW'(7);
                M1dN1 = MW'(5);
            end
            if (c == 4) start = 1'b0;
            expect_at(c, ea, ee, el);
            total++;
            if ({rd_addr_A, rd_en_A, last_k_A, busy, done} !== {ea, ee, el, (c <= 9), (c == 10)}) begin
                bad++;
                $display("[TB] FAIL restart_ignored c=%0d got=%h/%b/%b%b want=%h/%b/%b%b", c,
                         rd_addr_A, rd_en_A, busy, done, ea, ee, (c <= 9), (c == 10));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_stall();
        test_zero_dim();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
